// File: rtl/sprite_table_arbiter.sv
// sprite_table_arbiter
// Arbitrates sprite descriptor writes from N_REQ requesters into the sprite
// table during vertical blanking. A pass starts on a vblank rising edge
// (unless game_over), latches the pending requests, then alternates
// SCAN/WRITE until nothing eligible remains or vblank drops.
// Optional feature macro: SPRITE_ARB_ROUND_ROBIN_EN selects round-robin
// grant order starting after the previous grant; without it the lowest
// eligible index wins.
module sprite_table_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vblank,
  input  logic                     game_over,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  req_dina,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  output logic [N_REQ-1:0]         ack,
  output logic                     wea,
  output logic [ADDR_W-1:0]        addra,
  output logic [DATA_W-1:0]        dina,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                vblank_d_r;
  logic [N_REQ-1:0]    pending_r, pending_s;
  logic [GW-1:0]       last_grant_r, last_grant_s;
  logic [N_REQ-1:0]    eligible_s;
  logic [GW-1:0]       grant_s;
  logic [N_REQ-1:0]    ack_s;
  logic                wea_s;
  logic [ADDR_W-1:0]   addra_s;
  logic [DATA_W-1:0]   dina_s;
  logic                frame_done_s;
  logic                overrun_s;

`ifdef SPRITE_ARB_ROUND_ROBIN_EN
  // First eligible index scanning upward from last+1 with wrap-around.
  // Walking the offsets from largest to smallest lets the nearest one win.
  function automatic logic [GW-1:0] pick_grant(input logic [N_REQ-1:0] elig,
                                               input logic [GW-1:0]    last);
    logic [GW-1:0] res;
    int            idx;
    res = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = int'(last) + off;
      idx = (idx >= N_REQ) ? (idx - N_REQ) : idx;
      res = elig[idx] ? GW'(idx) : res;
    end
    return res;
  endfunction

  assign grant_s = pick_grant(eligible_s, last_grant_r);
`else
  // Fixed priority: lowest eligible index wins.
  function automatic logic [GW-1:0] pick_grant(input logic [N_REQ-1:0] elig);
    logic [GW-1:0] res;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      res = elig[i] ? GW'(i) : res;
    end
    return res;
  endfunction

  assign grant_s = pick_grant(eligible_s);

  // last_grant is still tracked in fixed-priority builds but not consumed.
  logic unused_last_grant_s;
  assign unused_last_grant_s = ^last_grant_r;
`endif

  assign eligible_s = pending_r & req;

  // Next-state and next-output logic; outputs are computed for the state being
  // entered so the registered copies line up with that state.
  always_comb begin
    state_s      = state_r;
    pending_s    = pending_r;
    last_grant_s = last_grant_r;
    ack_s        = '0;
    wea_s        = 1'b0;
    addra_s      = '0;
    dina_s       = '0;
    frame_done_s = 1'b0;
    overrun_s    = overrun_r_q();
    case (state_r)
      IDLE: begin
        if (vblank && !vblank_d_r && !game_over) begin
          pending_s = req;
          state_s   = SCAN;
        end else begin
          state_s   = IDLE;
        end
      end
      SCAN: begin
        if (!vblank) begin
          // Blanking ended mid-pass: stop issuing writes.
          state_s      = DONE;
          frame_done_s = 1'b1;
          if (eligible_s != '0) begin
            overrun_s = 1'b1;
          end else begin
            overrun_s = overrun;
          end
        end else if (eligible_s == '0) begin
          state_s      = DONE;
          frame_done_s = 1'b1;
        end else begin
          state_s            = WRITE;
          wea_s              = 1'b1;
          ack_s[grant_s]     = 1'b1;
          addra_s            = req_addr[int'(grant_s)*ADDR_W +: ADDR_W];
          dina_s             = req_dina[int'(grant_s)*DATA_W +: DATA_W];
          pending_s[grant_s] = 1'b0;
          last_grant_s       = grant_s;
        end
      end
      WRITE: begin
        state_s = SCAN;
      end
      DONE: begin
        pending_s = '0;
        state_s   = IDLE;
      end
      default: begin
        pending_s = '0;
        state_s   = IDLE;
      end
    endcase
  end

  // Current sticky overrun value, used as the hold default.
  function automatic logic overrun_r_q();
    return overrun;
  endfunction

  // State register and vblank edge-detect delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      pending_r    <= '0;
      last_grant_r <= LAST_IDX;
      vblank_d_r   <= 1'b1;
    end else begin
      state_r      <= state_s;
      pending_r    <= pending_s;
      last_grant_r <= last_grant_s;
      vblank_d_r   <= vblank;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack        <= '0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      ack        <= ack_s;
      wea        <= wea_s;
      addra      <= addra_s;
      dina       <= dina_s;
      frame_done <= frame_done_s;
      overrun    <= overrun_s;
    end
  end

endmodule
